// File: rtl/mem_access_unit_if.sv
// Request/response channel between the core (master) and mem_access_unit (slave).
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Sequences LOAD/STORE/SWAP requests onto a single-port memory and returns
// the read (or old) data over a valid/ready response channel.
module mem_access_unit #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_access_unit_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] o_mem_address,
    output logic [DATA_WIDTH-1:0] o_mem_in,
    output logic                  o_mem_write,
    input  logic [DATA_WIDTH-1:0] i_mem_out
);

    localparam int               CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_SWAP  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    state_e                r_state;
    op_e                   r_op;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_resp_err;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_in;
    logic                  r_mem_write;

    logic                  w_req_fire;
    logic                  w_resp_fire;
    op_e                   w_req_op;

    assign w_req_fire  = bus.req_valid & r_req_ready;
    assign w_resp_fire = r_resp_valid & bus.resp_ready;
    assign w_req_op    = op_e'(bus.req_op);

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_op          <= OP_LOAD;
            r_cnt         <= '0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_rdata  <= '0;
            r_resp_err    <= 1'b0;
            r_mem_address <= '0;
            r_mem_in      <= '0;
            r_mem_write   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_fire) begin
                        r_op          <= w_req_op;
                        r_mem_address <= bus.req_addr;
                        r_mem_in      <= bus.req_wdata;
                        r_req_ready   <= 1'b0;
                        case (w_req_op)
                            OP_LOAD, OP_SWAP: begin
                                r_state <= ST_READ;
                                r_cnt   <= CNT_INIT;
                            end
                            OP_STORE: begin
                                r_state     <= ST_WRITE;
                                r_mem_write <= 1'b1;
                            end
                            default: begin
                                r_state      <= ST_RESP;
                                r_resp_valid <= 1'b1;
                                r_resp_err   <= 1'b1;
                                r_resp_rdata <= '0;
                            end
                        endcase
                    end
                end

                ST_READ: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_resp_rdata <= i_mem_out;
                        // A SWAP goes straight to its write so no request can slip in between.
                        if (r_op == OP_SWAP) begin
                            r_state     <= ST_WRITE;
                            r_mem_write <= 1'b1;
                        end else begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                        end
                    end
                end

                ST_WRITE: begin
                    r_mem_write  <= 1'b0;
                    r_state      <= ST_RESP;
                    r_resp_valid <= 1'b1;
                    if (r_op == OP_STORE) begin
                        r_resp_rdata <= '0;
                    end
                end

                ST_RESP: begin
                    if (w_resp_fire) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end

                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_mem_write  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;

    assign o_mem_address  = r_mem_address;
    assign o_mem_in       = r_mem_in;
    assign o_mem_write    = r_mem_write;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: one instance with READ_LATENCY=1 and one
// with READ_LATENCY=3, each attached to a behavioural memory and checked against a model.
module tb_mem_access_unit;

    localparam int AW = 8;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus is shared; sel picks which DUT (1 or 3) sees it and is observed.
    int          sel        = 1;
    logic        req_valid  = 1'b0;
    logic [1:0]  req_op     = 2'b00;
    logic [7:0]  req_addr   = 8'h00;
    logic [7:0]  req_wdata  = 8'h00;
    logic        resp_ready = 1'b0;
    logic        bd_we      = 1'b0;
    logic [7:0]  bd_addr    = 8'h00;
    logic [7:0]  bd_data    = 8'h00;

    mem_access_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    mem_access_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

    logic [AW-1:0] mem_address1, mem_address3;
    logic [DW-1:0] mem_in1, mem_in3, mem_out1, mem_out3;
    logic          mem_write1, mem_write3;

    assign bus1.req_valid  = req_valid && (sel == 1);
    assign bus1.req_op     = req_op;
    assign bus1.req_addr   = req_addr;
    assign bus1.req_wdata  = req_wdata;
    assign bus1.resp_ready = resp_ready && (sel == 1);
    assign bus3.req_valid  = req_valid && (sel == 3);
    assign bus3.req_op     = req_op;
    assign bus3.req_addr   = req_addr;
    assign bus3.req_wdata  = req_wdata;
    assign bus3.resp_ready = resp_ready && (sel == 3);

    mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus1),
        .o_mem_address (mem_address1),
        .o_mem_in      (mem_in1),
        .o_mem_write   (mem_write1),
        .i_mem_out     (mem_out1)
    );

    mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)) u_dut3 (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus3),
        .o_mem_address (mem_address3),
        .o_mem_in      (mem_in3),
        .o_mem_write   (mem_write3),
        .i_mem_out     (mem_out3)
    );

    // Memory instances: asynchronous read, write on the rising edge; backdoor for preloading.
    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    assign mem_out1 = mem1[mem_address1];
    assign mem_out3 = mem3[mem_address3];
    always @(posedge clk) begin
        if (mem_write1)                mem1[mem_address1] <= mem_in1;
        else if (bd_we && sel == 1)    mem1[bd_addr]      <= bd_data;
        if (mem_write3)                mem3[mem_address3] <= mem_in3;
        else if (bd_we && sel == 3)    mem3[bd_addr]      <= bd_data;
    end

    logic       o_req_ready, o_resp_valid, o_resp_err, o_mem_write;
    logic [7:0] o_resp_rdata, o_mem_address, o_mem_in;
    assign o_req_ready   = (sel == 3) ? bus3.req_ready  : bus1.req_ready;
    assign o_resp_valid  = (sel == 3) ? bus3.resp_valid : bus1.resp_valid;
    assign o_resp_rdata  = (sel == 3) ? bus3.resp_rdata : bus1.resp_rdata;
    assign o_resp_err    = (sel == 3) ? bus3.resp_err   : bus1.resp_err;
    assign o_mem_address = (sel == 3) ? mem_address3    : mem_address1;
    assign o_mem_in      = (sel == 3) ? mem_in3         : mem_in1;
    assign o_mem_write   = (sel == 3) ? mem_write3      : mem_write1;

    // Reference memory contents, indexed [sel==3][addr].
    logic [7:0] model [2][256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = addr; bd_data = data;
        @(posedge clk); #1;
        bd_we = 1'b0;
        model[(sel == 3) ? 1 : 0][addr] = data;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  o_req_ready,   1);
        check({tag, "_resp_valid"}, o_resp_valid,  0);
        check({tag, "_resp_rdata"}, o_resp_rdata,  0);
        check({tag, "_resp_err"},   o_resp_err,    0);
        check({tag, "_mem_addr"},   o_mem_address, 0);
        check({tag, "_mem_in"},     o_mem_in,      0);
        check({tag, "_mem_write"},  o_mem_write,   0);
    endtask

    // Waits for req_ready, presents a request and returns just after the accept edge.
    task automatic start_req(input logic [1:0] op, input logic [7:0] addr,
                             input logic [7:0] wdata, input bit hold);
        int n = 0;
        @(negedge clk);
        while (!o_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", o_req_ready, 1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        if (hold) begin
            req_op   = 2'b00;
            req_addr = ~addr;
        end else begin
            req_valid = 1'b0;
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [7:0] addr,
                         input logic [7:0] wdata, input int stall, input bit hold);
        logic [7:0] exp_rdata, old, wr_addr, wr_data;
        logic       exp_err;
        int         exp_lat, exp_wr, lat, nwr, lat_l, mi;
        bit         ready_low, addr_ok;
        mi    = (sel == 3) ? 1 : 0;
        lat_l = (sel == 3) ? 3 : 1;
        old   = model[mi][addr];
        case (op)
            2'b00:   begin exp_rdata = old;   exp_err = 0; exp_lat = 1 + lat_l; exp_wr = 0; end
            2'b01:   begin exp_rdata = 8'h00; exp_err = 0; exp_lat = 2;         exp_wr = 1;
                           model[mi][addr] = wdata; end
            2'b10:   begin exp_rdata = old;   exp_err = 0; exp_lat = 2 + lat_l; exp_wr = 1;
                           model[mi][addr] = wdata; end
            default: begin exp_rdata = 8'h00; exp_err = 1; exp_lat = 1;         exp_wr = 0; end
        endcase

        start_req(op, addr, wdata, hold);
        lat = 0; nwr = 0; ready_low = 1; addr_ok = 1; wr_addr = 0; wr_data = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (o_mem_write) begin
                nwr++;
                wr_addr = o_mem_address;
                wr_data = o_mem_in;
            end
            if (o_req_ready) ready_low = 0;
            if (o_mem_address !== addr || o_mem_in !== wdata) addr_ok = 0;
            if (o_resp_valid) begin
                lat = n;
                break;
            end
        end
        req_valid = 1'b0;
        check({tag, "_latency"},   lat,       exp_lat);
        check({tag, "_writes"},    nwr,       exp_wr);
        check({tag, "_rdata"},     o_resp_rdata, exp_rdata);
        check({tag, "_err"},       o_resp_err,   exp_err);
        check({tag, "_busy"},      ready_low, 1);
        check({tag, "_addr_held"}, addr_ok,   1);
        if (exp_wr != 0) begin
            check({tag, "_wr_addr"}, wr_addr, addr);
            check({tag, "_wr_data"}, wr_data, wdata);
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, "_stall_valid"}, o_resp_valid, 1);
            check({tag, "_stall_rdata"}, o_resp_rdata, exp_rdata);
            check({tag, "_stall_err"},   o_resp_err,   exp_err);
            check({tag, "_stall_ready"}, o_req_ready,  0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_done_valid"}, o_resp_valid, 0);
        check({tag, "_done_ready"}, o_req_ready,  1);
        check({tag, "_done_err"},   o_resp_err,   0);
    endtask

    task automatic random_ops(input string tag, input int count);
        int         r;
        logic [1:0] op;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 9);
            op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            do_op(tag, op, 8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 2), 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        sel = 1; check_reset_outputs("rst1_async");
        sel = 3; check_reset_outputs("rst3_async");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        sel = 1; check_reset_outputs("rst1_release");

        for (int a = 0; a < 16; a++) poke(8'(a), 8'($urandom));
        poke(8'd42, 8'd0);
        poke(8'h80, 8'hA5);
        poke(8'd5, 8'h3C);

        do_op("store23", 2'b01, 8'd23, 8'd23, 0, 1'b0);
        do_op("load23",  2'b00, 8'd23, 8'h00, 0, 1'b0);
        do_op("load42",  2'b00, 8'd42, 8'h00, 0, 1'b0);
        poke(8'd42, 8'd7);
        do_op("swap42",  2'b10, 8'd42, 8'd99, 0, 1'b1);
        do_op("load42b", 2'b00, 8'd42, 8'h00, 0, 1'b0);
        do_op("loadA5",  2'b00, 8'h80, 8'h00, 5, 1'b0);
        do_op("rsvd",    2'b11, 8'd5,  8'h11, 0, 1'b0);
        do_op("load5",   2'b00, 8'd5,  8'h00, 0, 1'b0);

        // Reset during the WRITE cycle of a STORE: the write must not land.
        poke(8'd30, 8'h11);
        start_req(2'b01, 8'd30, 8'h5A, 1'b0);
        @(negedge clk);
        check("rst_mid_write_pre", o_mem_write, 1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_mid_after");
        do_op("load30_after_rst", 2'b00, 8'd30, 8'h00, 0, 1'b0);

        random_ops("rnd1", 30);

        sel = 3;
        for (int a = 0; a < 16; a++) poke(8'(a), 8'($urandom));
        poke(8'd42, 8'h5E);
        do_op("l3_load42", 2'b00, 8'd42, 8'h00, 0, 1'b0);
        do_op("l3_swap42", 2'b10, 8'd42, 8'h21, 2, 1'b1);
        do_op("l3_store",  2'b01, 8'd42, 8'h77, 0, 1'b0);
        do_op("l3_rsvd",   2'b11, 8'd9,  8'h00, 1, 1'b0);
        random_ops("rnd3", 30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
